// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB,
// drives datapath strobes, counts retired instructions and guards every
// memory access with a wait-cycle timeout.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic [2:0]  state,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        halted,
  output logic        illegal,
  output logic        bus_err,
  output logic [31:0] retire_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_t      r_state;
  state_t      w_nextState;
  logic [15:0] r_waitCnt;
  logic [16:0] w_waitInc;
  logic        w_timeout;
  logic [31:0] r_retireCnt;
  logic        r_illegal;
  logic        r_busErr;
  logic        w_retire;
  logic        w_setIllegal;
  logic        w_setBusErr;
  logic        w_legal;

  // The count this cycle would reach if the memory keeps stalling; the
  // access is abandoned once that count hits the timeout budget.
  assign w_waitInc = {1'b0, r_waitCnt} + 17'd1;
  assign w_timeout = (w_waitInc >= 17'(MEM_TIMEOUT));

  // Opcode legality check, used in DECODE to trap unknown instructions.
  always_comb begin
    w_legal = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE,
      OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM: w_legal = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  // Next-state and strobe decode; everything is held at zero while reset is
  // asserted so an interrupted memory request is dropped immediately.
  always_comb begin
    w_nextState  = r_state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'd0;
    rf_we        = 1'b0;
    wb_sel       = 2'd0;
    halted       = 1'b0;
    w_retire     = 1'b0;
    w_setIllegal = 1'b0;
    w_setBusErr  = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we       = 1'b1;
            w_nextState = S_DECODE;
          end else if (w_timeout) begin
            w_nextState = S_HALT;
            w_setBusErr = 1'b1;
          end
        end
        S_DECODE: begin
          if (w_legal) begin
            w_nextState = S_EXEC;
          end else begin
            w_nextState  = S_HALT;
            w_setIllegal = 1'b1;
          end
        end
        S_EXEC: begin
          case (opcode)
            OP_LOAD, OP_STORE: w_nextState = S_MEM;
            OP_BRANCH: begin
              pc_we       = 1'b1;
              pc_sel      = branch_taken ? 2'd1 : 2'd0;
              w_retire    = 1'b1;
              w_nextState = S_FETCH;
            end
            OP_FENCE: begin
              pc_we       = 1'b1;
              w_retire    = 1'b1;
              w_nextState = S_FETCH;
            end
            OP_SYSTEM: begin
              w_retire    = 1'b1;
              w_nextState = S_HALT;
            end
            default: w_nextState = S_WB;
          endcase
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (opcode == OP_STORE);
          if (mem_ready) begin
            if (opcode == OP_STORE) begin
              pc_we       = 1'b1;
              w_retire    = 1'b1;
              w_nextState = S_FETCH;
            end else begin
              w_nextState = S_WB;
            end
          end else if (w_timeout) begin
            w_nextState = S_HALT;
            w_setBusErr = 1'b1;
          end
        end
        S_WB: begin
          rf_we       = 1'b1;
          pc_we       = 1'b1;
          w_retire    = 1'b1;
          w_nextState = S_FETCH;
          case (opcode)
            OP_LOAD:         wb_sel = 2'd1;
            OP_JAL, OP_JALR: wb_sel = 2'd2;
            OP_LUI:          wb_sel = 2'd3;
            default:         wb_sel = 2'd0;
          endcase
          case (opcode)
            OP_JAL:  pc_sel = 2'd1;
            OP_JALR: pc_sel = 2'd2;
            default: pc_sel = 2'd0;
          endcase
        end
        S_HALT: halted = 1'b1;
        default: w_nextState = S_HALT;
      endcase
    end
  end

  // State register, retire counter, memory wait counter and sticky errors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_waitCnt   <= 16'd0;
      r_retireCnt <= 32'd0;
      r_illegal   <= 1'b0;
      r_busErr    <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_retire) begin
        r_retireCnt <= r_retireCnt + 32'd1;
      end
      if (w_setIllegal) begin
        r_illegal <= 1'b1;
      end
      if (w_setBusErr) begin
        r_busErr <= 1'b1;
      end
      if ((w_nextState != r_state) &&
          ((w_nextState == S_FETCH) || (w_nextState == S_MEM))) begin
        r_waitCnt <= 16'd0;
      end else if (mem_req && !mem_ready) begin
        r_waitCnt <= w_waitInc[15:0];
      end
    end
  end

  assign state      = r_state;
  assign retire_cnt = r_retireCnt;
  assign illegal    = r_illegal;
  assign bus_err    = r_busErr;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl. Inputs change on the
// falling edge and outputs are compared 1 time unit later.
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic        memReady = 1'b0;
  logic        branchTaken = 1'b0;

  logic [2:0]  state;
  logic        memReq, memWe, memAddrSel, irWe, pcWe, rfWe;
  logic [1:0]  pcSel, wbSel;
  logic        halted, illegal, busErr;
  logic [31:0] retireCnt;

  logic [2:0]  t4State;
  logic        t4MemReq, t4MemWe, t4MemAddrSel, t4IrWe, t4PcWe, t4RfWe;
  logic [1:0]  t4PcSel, t4WbSel;
  logic        t4Halted, t4Illegal, t4BusErr;
  logic [31:0] t4RetireCnt;

  logic [12:0] obsVec;
  logic [12:0] e;

  int compared = 0;
  int mismatched = 0;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(memReady),
    .branch_taken(branchTaken), .state(state), .mem_req(memReq),
    .mem_we(memWe), .mem_addr_sel(memAddrSel), .ir_we(irWe), .pc_we(pcWe),
    .pc_sel(pcSel), .rf_we(rfWe), .wb_sel(wbSel), .halted(halted),
    .illegal(illegal), .bus_err(busErr), .retire_cnt(retireCnt)
  );

  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut4 (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(memReady),
    .branch_taken(branchTaken), .state(t4State), .mem_req(t4MemReq),
    .mem_we(t4MemWe), .mem_addr_sel(t4MemAddrSel), .ir_we(t4IrWe),
    .pc_we(t4PcWe), .pc_sel(t4PcSel), .rf_we(t4RfWe), .wb_sel(t4WbSel),
    .halted(t4Halted), .illegal(t4Illegal), .bus_err(t4BusErr),
    .retire_cnt(t4RetireCnt)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  assign obsVec = {state, memReq, memWe, memAddrSel, irWe, pcWe, pcSel, rfWe, wbSel};

  function automatic logic [12:0] expVec(input int st, input int mreq, input int mwe,
                                         input int masel, input int irwe, input int pcwe,
                                         input int pcsel, input int rfwe, input int wbsel);
    return {3'(st), 1'(mreq), 1'(mwe), 1'(masel), 1'(irwe), 1'(pcwe),
            2'(pcsel), 1'(rfwe), 2'(wbsel)};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [6:0] op, input logic rdy, input logic bt);
    opcode = op;
    memReady = rdy;
    branchTaken = bt;
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(7'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(OP_IMM, 1'b1, 1'b0);
    e = expVec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    compared++;
    if (obsVec !== e) begin mismatched++; $display("[TB] FAIL reset_strobes: got %b want %b", obsVec, e); end
    compared++;
    if ({halted, illegal, busErr, retireCnt} !== 35'd0) begin
      mismatched++; $display("[TB] FAIL reset_flags: got %b/%b/%b/%0d want 0/0/0/0", halted, illegal, busErr, retireCnt);
    end
    tick();
    rst = 1'b0;
    applyStimulus(OP_IMM, 1'b0, 1'b0);
    e = expVec(0, 1, 0, 0, 0, 0, 0, 0, 0);
    compared++;
    if (obsVec !== e) begin mismatched++; $display("[TB] FAIL reset_release: got %b want %b", obsVec, e); end
  endtask

  task automatic test_addi();
    doReset();
    applyStimulus(OP_IMM, 1'b1, 1'b0);
    e = expVec(0, 1, 0, 0, 1, 0, 0, 0, 0);
    compared++;
    if (obsVec !== e) begin mismatched++; $display("[TB] FAIL addi_fetch: got %b want %b", obsVec, e); end
    tick(); applyStimulus(OP_IMM, 1'b0, 1'b0);
    e = expVec(1, 0, 0, 0, 0, 0, 0, 0, 0);
    compared++;
    if (obsVec !== e) begin mismatched++; $display("[TB] FAIL addi_decode: got %b want %b", obsVec, e); end
    tick(); applyStimulus(OP_IMM, 1'b0, 1'b0);
    e = expVec(2, 0, 0, 0, 0, 0, 0, 0, 0);
    compared++;
    if (obsVec !== e) begin mismatched++; $display("[TB] FAIL addi_exec: got %b want %b", obsVec, e); end
    tick(); applyStimulus(OP_IMM, 1'b0, 1'b0);
    e = expVec(4, 0, 0, 0, 0, 1, 0, 1, 0);
    compared++;
    if (obsVec !== e) begin mismatched++; $display("[TB] FAIL addi_wb: got %b want %b", obsVec, e); end
    tick(); applyStimulus(OP_IMM, 1'b0, 1'b0);
    compared++;
    if (state !== 3'd0 || retireCnt !== 32'd1) begin
      mismatched++; $display("[TB] FAIL addi_retire: got state %0d cnt %0d want 0/1", state, retireCnt);
    end
  endtask

  task automatic test_load();
    doReset();
    applyStimulus(OP_LOAD, 1'b1, 1'b0); tick();
    applyStimulus(OP_LOAD, 1'b0, 1'b0); tick();
    applyStimulus(OP_LOAD, 1'b0, 1'b0); tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(OP_LOAD, (i == 3), 1'b0);
      e = expVec(3, 1, 0, 1, 0, 0, 0, 0, 0);
      compared++;
      if (obsVec !== e) begin mismatched++; $display("[TB] FAIL load_mem%0d: got %b want %b", i, obsVec, e); end
      tick();
    end
    applyStimulus(OP_LOAD, 1'b0, 1'b0);
    e = expVec(4, 0, 0, 0, 0, 1, 0, 1, 1);
    compared++;
    if (obsVec !== e) begin mismatched++; $display("[TB] FAIL load_wb: got %b want %b", obsVec, e); end
    tick(); applyStimulus(OP_LOAD, 1'b0, 1'b0);
    compared++;
    if (state !== 3'd0 || retireCnt !== 32'd1) begin
      mismatched++; $display("[TB] FAIL load_retire: got state %0d cnt %0d want 0/1", state, retireCnt);
    end
  endtask

  task automatic test_branch();
    doReset();
    applyStimulus(OP_BRANCH, 1'b1, 1'b1); tick();
    applyStimulus(OP_BRANCH, 1'b0, 1'b1); tick();
    applyStimulus(OP_BRANCH, 1'b0, 1'b1);
    e = expVec(2, 0, 0, 0, 0, 1, 1, 0, 0);
    compared++;
    if (obsVec !== e) begin mismatched++; $display("[TB] FAIL branch_taken_exec: got %b want %b", obsVec, e); end
    tick(); applyStimulus(OP_BRANCH, 1'b1, 1'b0);
    compared++;
    if (state !== 3'd0 || retireCnt !== 32'd1) begin
      mismatched++; $display("[TB] FAIL branch_no_wb: got state %0d cnt %0d want 0/1", state, retireCnt);
    end
    tick(); applyStimulus(OP_BRANCH, 1'b0, 1'b0); tick();
    applyStimulus(OP_BRANCH, 1'b0, 1'b0);
    e = expVec(2, 0, 0, 0, 0, 1, 0, 0, 0);
    compared++;
    if (obsVec !== e) begin mismatched++; $display("[TB] FAIL branch_not_taken_exec: got %b want %b", obsVec, e); end
    tick(); applyStimulus(OP_BRANCH, 1'b0, 1'b0);
    compared++;
    if (retireCnt !== 32'd2) begin mismatched++; $display("[TB] FAIL branch_retire2: got %0d want 2", retireCnt); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] tblOp [5];
    int tblWb [5];
    int tblPc [5];
    tblOp = '{OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_REG};
    tblWb = '{2, 2, 3, 0, 0};
    tblPc = '{1, 2, 0, 0, 0};
    doReset();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(tblOp[k], 1'b1, 1'b0); tick();
      applyStimulus(tblOp[k], 1'b0, 1'b0); tick();
      applyStimulus(tblOp[k], 1'b0, 1'b0); tick();
      applyStimulus(tblOp[k], 1'b0, 1'b0);
      e = expVec(4, 0, 0, 0, 0, 1, tblPc[k], 1, tblWb[k]);
      compared++;
      if (obsVec !== e) begin mismatched++; $display("[TB] FAIL wb_op%b: got %b want %b", tblOp[k], obsVec, e); end
      tick();
    end
    applyStimulus(OP_IMM, 1'b0, 1'b0);
    compared++;
    if (state !== 3'd0 || retireCnt !== 32'd5) begin
      mismatched++; $display("[TB] FAIL b2b_retire: got state %0d cnt %0d want 0/5", state, retireCnt);
    end
  endtask

  task automatic test_store_fence_system();
    doReset();
    applyStimulus(OP_STORE, 1'b1, 1'b0); tick();
    applyStimulus(OP_STORE, 1'b0, 1'b0); tick();
    applyStimulus(OP_STORE, 1'b0, 1'b0); tick();
    applyStimulus(OP_STORE, 1'b1, 1'b0);
    e = expVec(3, 1, 1, 1, 0, 1, 0, 0, 0);
    compared++;
    if (obsVec !== e) begin mismatched++; $display("[TB] FAIL store_mem: got %b want %b", obsVec, e); end
    tick(); applyStimulus(OP_FENCE, 1'b1, 1'b0);
    compared++;
    if (state !== 3'd0 || retireCnt !== 32'd1) begin
      mismatched++; $display("[TB] FAIL store_retire: got state %0d cnt %0d want 0/1", state, retireCnt);
    end
    tick(); applyStimulus(OP_FENCE, 1'b0, 1'b0); tick();
    applyStimulus(OP_FENCE, 1'b0, 1'b0);
    e = expVec(2, 0, 0, 0, 0, 1, 0, 0, 0);
    compared++;
    if (obsVec !== e) begin mismatched++; $display("[TB] FAIL fence_exec: got %b want %b", obsVec, e); end
    tick(); applyStimulus(OP_SYSTEM, 1'b1, 1'b0); tick();
    applyStimulus(OP_SYSTEM, 1'b0, 1'b0); tick();
    applyStimulus(OP_SYSTEM, 1'b0, 1'b0);
    e = expVec(2, 0, 0, 0, 0, 0, 0, 0, 0);
    compared++;
    if (obsVec !== e) begin mismatched++; $display("[TB] FAIL system_exec: got %b want %b", obsVec, e); end
    tick(); applyStimulus(OP_SYSTEM, 1'b0, 1'b0);
    compared++;
    if (state !== 3'd5 || halted !== 1'b1 || illegal !== 1'b0 || retireCnt !== 32'd3) begin
      mismatched++; $display("[TB] FAIL system_halt: got st %0d h %b ill %b cnt %0d want 5/1/0/3", state, halted, illegal, retireCnt);
    end
  endtask

  task automatic test_illegal();
    doReset();
    applyStimulus(OP_BAD, 1'b1, 1'b0); tick();
    applyStimulus(OP_BAD, 1'b0, 1'b0);
    e = expVec(1, 0, 0, 0, 0, 0, 0, 0, 0);
    compared++;
    if (obsVec !== e) begin mismatched++; $display("[TB] FAIL illegal_decode: got %b want %b", obsVec, e); end
    tick(); applyStimulus(OP_BAD, 1'b0, 1'b0);
    compared++;
    if (state !== 3'd5 || illegal !== 1'b1 || halted !== 1'b1 || retireCnt !== 32'd0) begin
      mismatched++; $display("[TB] FAIL illegal_halt: got st %0d ill %b h %b cnt %0d want 5/1/1/0", state, illegal, halted, retireCnt);
    end
    for (int i = 0; i < 20; i++) begin
      applyStimulus(OP_BAD, i[0], i[1]);
      e = expVec(5, 0, 0, 0, 0, 0, 0, 0, 0);
      compared++;
      if (obsVec !== e || illegal !== 1'b1) begin
        mismatched++; $display("[TB] FAIL illegal_hold%0d: got %b ill %b want %b ill 1", i, obsVec, illegal, e);
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(OP_IMM, 1'b0, 1'b0);
      compared++;
      if (t4State !== 3'd0 || t4MemReq !== 1'b1) begin
        mismatched++; $display("[TB] FAIL timeout_wait%0d: got st %0d req %b want 0/1", i, t4State, t4MemReq);
      end
      tick();
    end
    applyStimulus(OP_IMM, 1'b0, 1'b0);
    compared++;
    if (t4State !== 3'd5 || t4BusErr !== 1'b1 || t4Halted !== 1'b1 || t4MemReq !== 1'b0) begin
      mismatched++; $display("[TB] FAIL timeout_halt: got st %0d be %b h %b req %b want 5/1/1/0", t4State, t4BusErr, t4Halted, t4MemReq);
    end
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(OP_IMM, (i == 3), 1'b0);
      tick();
    end
    applyStimulus(OP_IMM, 1'b0, 1'b0);
    compared++;
    if (t4State !== 3'd1 || t4BusErr !== 1'b0) begin
      mismatched++; $display("[TB] FAIL timeout_ready_wins: got st %0d be %b want 1/0", t4State, t4BusErr);
    end
  endtask

  task automatic test_reset_mid_store();
    doReset();
    applyStimulus(OP_IMM, 1'b1, 1'b0); tick();
    applyStimulus(OP_IMM, 1'b0, 1'b0); tick();
    tick(); tick();
    applyStimulus(OP_STORE, 1'b1, 1'b0); tick();
    applyStimulus(OP_STORE, 1'b0, 1'b0); tick();
    tick();
    applyStimulus(OP_STORE, 1'b0, 1'b0);
    e = expVec(3, 1, 1, 1, 0, 0, 0, 0, 0);
    compared++;
    if (obsVec !== e || retireCnt !== 32'd1) begin
      mismatched++; $display("[TB] FAIL midstore_pre: got %b cnt %0d want %b cnt 1", obsVec, retireCnt, e);
    end
    #1;
    rst = 1'b1;
    #1;
    e = expVec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    compared++;
    if (obsVec !== e || retireCnt !== 32'd0) begin
      mismatched++; $display("[TB] FAIL midstore_reset: got %b cnt %0d want %b cnt 0", obsVec, retireCnt, e);
    end
    tick();
    rst = 1'b0;
    #1;
    compared++;
    if (memReq !== 1'b1 || state !== 3'd0) begin
      mismatched++; $display("[TB] FAIL midstore_release: got req %b st %0d want 1/0", memReq, state);
    end
  endtask

  // Guard against a hung run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence.
  initial begin
    $display("[TB] multicycle_ctrl directed tests");
    test_reset();
    test_addi();
    test_load();
    test_branch();
    test_back_to_back();
    test_store_fence_system();
    test_illegal();
    test_timeout();
    test_reset_mid_store();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
